product_hex_display: RTL

- Downstream stage of the radix-4 multiplier datapath.
- Captures the multiplier's product when the multiplier signals completion.
- The user requests the captured product with the active-low putOut push button; the block debounces it.
- Shows the product as four hex digits on active-low seven-segment displays (out3..out0).

---
 rtl/product_hex_display.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/product_hex_display.sv
// Holds the radix-4 multiplier product and shows it as four active-low hex digits on a debounced button press.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits; out0 always shows.
module product_hex_display #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [WIDTH-1:0] result,
    input  logic             putOut,
    output logic             shown,
    output logic [0:6]       out0,
    output logic [0:6]       out1,
    output logic [0:6]       out2,
    output logic [0:6]       out3
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURED,
        SHOW
    } state_t;

    state_t           state_q;
    logic [15:0]      hold_q;
    logic [15:0]      result_ext;
    logic             ready_q;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cap, press;
    logic             shown_q;
    logic [0:6]       out0_q, out1_q, out2_q, out3_q;
    logic [0:6]       show_seg [4];

    function automatic logic [0:6] hex_seg(input logic [3:0] nib);
        logic [0:6] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_comb begin
        result_ext             = '0;
        result_ext[WIDTH-1:0]  = result;
    end

    assign cap   = ready && !ready_q;
    assign press = !s2_q && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (s2_q) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Digit patterns for the held value; leading-zero blanking scans from out3 down to out1.
    always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
        logic lead;
`endif
        for (int unsigned i = 0; i < 4; i++) begin
            show_seg[i] = hex_seg(hold_q[4*i +: 4]);
        end
`ifdef LEAD_ZERO_BLANK_EN
        lead = 1'b1;
        for (int unsigned i = 3; i >= 1; i--) begin
            lead = lead && (hold_q[4*i +: 4] == 4'h0);
            if (lead) begin
                show_seg[i] = '1;
            end
        end
`endif
    end

    // Button synchroniser and debounce counter; reset to the released level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            s1_q    <= putOut;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            ready_q <= ready;
        end
    end

    // A capture overrides a coincident press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            shown_q <= 1'b0;
            out0_q  <= '1;
            out1_q  <= '1;
            out2_q  <= '1;
            out3_q  <= '1;
        end else if (cap) begin
            state_q <= CAPTURED;
            hold_q  <= result_ext;
            shown_q <= 1'b0;
            out0_q  <= '1;
            out1_q  <= '1;
            out2_q  <= '1;
            out3_q  <= '1;
        end else if (press) begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                CAPTURED: begin
                    state_q <= SHOW;
                    shown_q <= 1'b1;
                    out0_q  <= show_seg[0];
                    out1_q  <= show_seg[1];
                    out2_q  <= show_seg[2];
                    out3_q  <= show_seg[3];
                end
                SHOW: begin
                    state_q <= CAPTURED;
                    shown_q <= 1'b0;
                    out0_q  <= '1;
                    out1_q  <= '1;
                    out2_q  <= '1;
                    out3_q  <= '1;
                end
                default: begin
                    state_q <= IDLE;
                    shown_q <= 1'b0;
                    out0_q  <= '1;
                    out1_q  <= '1;
                    out2_q  <= '1;
                    out3_q  <= '1;
                end
            endcase
        end
    end

    assign shown = shown_q;
    assign out0  = out0_q;
    assign out1  = out1_q;
    assign out2  = out2_q;
    assign out3  = out3_q;

endmodule
